// File: rtl/fifo_wr_arb_pkg.sv
// fifo_arb_pkg: arbiter state type and default parameters shared by the FIFO write arbiter files.
package fifo_arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   localparam int NREQ_DEF      = 4;
   localparam int WIDTH_DEF     = 8;
   localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester-side handshake and FIFO write port bundle for the write arbiter.
interface fifo_wr_arb_if #(
   parameter int NREQ  = fifo_arb_pkg::NREQ_DEF,
   parameter int WIDTH = fifo_arb_pkg::WIDTH_DEF
) ();
   localparam int IDW = $clog2(NREQ);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_wen;
   logic [IDW+WIDTH-1:0]  fifo_wdata;
   logic                  fifo_full;
   logic [IDW-1:0]        grant_id;
   logic                  busy;
   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wen, fifo_wdata, grant_id, busy
   );
   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wen, fifo_wdata, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin search starting one past last_grant.
module rr_pick #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [IDW-1:0]  winner,
   output logic            any
);
   logic [IDW-1:0] idx;
   // Walk from farthest to nearest so the nearest valid requester overwrites last.
   always_comb begin
      winner = '0;
      idx = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = IDW'((int'(last_grant) + i) % NREQ);
         if (req[idx]) winner = idx;
      end
   end
   assign any = |req;
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter merging NREQ bursting write requesters into one async FIFO write port.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input logic           wclk,
   input logic           wrstn,
   fifo_wr_arb_if.slave  bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int BCW = $clog2(MAX_BURST + 1);
   arb_state_t     state;
   logic [BCW-1:0] beat_cnt;
   logic [IDW-1:0] last_grant, gid, winner;
   logic           any, beat, done;
   rr_pick #(.NREQ(NREQ)) u_pick (
      .req(bus.req_valid),
      .last_grant(last_grant),
      .winner(winner),
      .any(any)
   );
   assign beat            = state == GRANT && bus.req_valid[gid] && !bus.fifo_full;
   assign done            = bus.req_last[gid] || beat_cnt == BCW'(MAX_BURST - 1);
   assign bus.fifo_wen    = beat;
   assign bus.req_ready   = beat ? NREQ'(1) << gid : '0;
   assign bus.fifo_wdata  = state == GRANT ? {gid, bus.req_data[int'(gid)*WIDTH +: WIDTH]} : '0;
   assign bus.grant_id    = gid;
   assign bus.busy        = state == GRANT;
   // Async clear drops the write strobe immediately, abandoning any partial packet.
   always_ff @(posedge wclk or negedge wrstn)
      if (!wrstn) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         last_grant <= IDW'(NREQ - 1);
         gid        <= '0;
      end else if (state == IDLE) begin
         if (any) begin
            state    <= GRANT;
            gid      <= winner;
            beat_cnt <= '0;
         end
      end else if (beat) begin
         if (done) begin
            state      <= IDLE;
            last_grant <= gid;
            gid        <= '0;
            beat_cnt   <= '0;
         end else beat_cnt <= beat_cnt + 1'b1;
      end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL provide parameter NREQ, default 4, the number of write requesters (range 2..8).
REQ-002 The block SHALL provide parameter WIDTH, default 8, the payload width per requester.
REQ-003 The block SHALL provide parameter MAX_BURST, default 4, the maximum beats per grant (range 1..15).
REQ-004 The block SHALL derive IDW = $clog2(NREQ) internally; it is not a port parameter.
REQ-005 wclk  in  1  write-domain clock; all logic is clocked on its rising edge.
REQ-006 wrstn  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NREQ  per-requester beat valid.
REQ-008 req_data  in  NREQ*WIDTH  per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_last  in  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-010 req_ready  out  NREQ  per-requester beat accept.
REQ-011 fifo_wen  out  1  write enable to the async FIFO write port.
REQ-012 fifo_wdata  out  IDW+WIDTH  {grant_id, payload} to the FIFO write port.
REQ-013 fifo_full  in  1  full flag from the async FIFO write domain.
REQ-014 grant_id  out  IDW  index of the current grant holder; 0 when idle.
REQ-015 busy  out  1  high while the arbiter is in GRANT.

Function
REQ-016 The state machine SHALL have exactly two states: IDLE and GRANT.
REQ-017 IDLE->GRANT: if any req_valid bit is high, the block SHALL register the winner and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-018 The winner SHALL be chosen round-robin: search starts at last_grant+1 modulo NREQ; the first requester with req_valid high wins.
REQ-019 A beat SHALL occur in GRANT when req_valid[grant_id]=1 and fifo_full=0.
REQ-020 fifo_wen and req_ready[grant_id] SHALL both equal the beat condition; they are combinational from registered state and these inputs.
REQ-021 req_ready SHALL be 0 for non-granted requesters, and all req_ready bits SHALL be 0 in IDLE.
REQ-022 fifo_wdata SHALL equal {grant_id, req_data[grant_id]} in GRANT and 0 in IDLE.
REQ-023 beat_cnt SHALL clear on entry to GRANT and increment on each beat.
REQ-024 GRANT->IDLE SHALL occur on a beat that has req_last=1 or beat_cnt=MAX_BURST-1; last_grant is updated to grant_id on that edge.
REQ-025 If the holder deasserts req_valid mid-packet, the block SHALL keep the grant and count no beat.
REQ-026 If fifo_full=1, the block SHALL issue no beat and SHALL keep the grant and beat_cnt unchanged.
REQ-027 A requester SHALL NOT be re-granted back-to-back while another requester has req_valid high in the IDLE cycle.
REQ-028 Exactly one IDLE bubble cycle SHALL separate consecutive grants.
REQ-029 A requester that raises req_valid while another holds the grant SHALL wait without loss; arbitration SHALL consider only IDLE cycles.

Reset
REQ-030 While wrstn=0, the block SHALL hold: state=IDLE, beat_cnt=0, last_grant=NREQ-1 (so requester 0 has first priority), grant_id=0.
REQ-031 While wrstn=0, every output SHALL be 0: fifo_wen=0, req_ready=0, busy=0, fifo_wdata=0.
REQ-032 Reset asserted mid-burst SHALL drop fifo_wen in the same cycle without waiting for a clock edge; the partial packet is abandoned.
REQ-033 After wrstn rises, the first grant SHALL follow REQ-017.

Structure
REQ-034 Package fifo_arb_pkg SHALL hold the arb_state_t enum (IDLE, GRANT) and the defaults for NREQ, WIDTH and MAX_BURST.
REQ-035 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: req vector and last_grant; outputs: winner index and any-valid).
REQ-036 fifo_wr_arb SHALL instantiate rr_pick once.

Verification
REQ-037 Reset then req_valid=4'b0001 with data 0x11, 0x22 and last on the second beat -> grant_id=0, busy=1 one cycle later, two fifo_wen pulses with fifo_wdata 0x011 and 0x022, then IDLE.
REQ-038 All four requesters valid continuously with single-beat packets -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-039 Requester 2 streams 6 beats with no last, MAX_BURST=4 -> 4 beats accepted, release, requester 2 re-granted after the bubble, then the remaining 2 beats.
REQ-040 fifo_full=1 for 3 cycles mid-burst -> fifo_wen=0 and req_ready=0 for those cycles; beat_cnt holds; no data is lost or duplicated.
REQ-041 wrstn pulled low after the 2nd beat of a 4-beat burst -> fifo_wen drops immediately; after release, requester 0 wins the first grant.
REQ-042 Scoreboard through a real async FIFO (wclk:rclk = 3:5) -> per-id payload order is preserved and packets are never interleaved within a burst.
